// File: rtl/i2s_unit_pkg.sv
// Shared constants, FSM state type and word-select decode for the I2S transmitter.
package i2s_unit_pkg;

  localparam int SCK_HALF_DEFAULT = 2;
  localparam int I2S_FRAME_BITS   = 64;
  localparam int I2S_SLOT_BITS    = 32;
  localparam int BIT_W            = $clog2(I2S_FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    PLAY     = 2'd2,
    STOPPING = 2'd3
  } state_t;

  // WS is high for bits 31..62 so it leads each channel's MSB by one bit.
  function automatic logic ws_for_bit(input logic [BIT_W-1:0] b);
    return (b >= BIT_W'(I2S_SLOT_BITS - 1)) && (b <= BIT_W'(I2S_FRAME_BITS - 2));
  endfunction

endpackage

// File: rtl/i2s_unit_clkgen.sv
// Bit-clock divider and bit counter; sck is registered, the strobes mark the
// cycle whose closing edge starts a new bit / a new frame.
module i2s_clkgen
  import i2s_unit_pkg::*;
#(
  parameter int SCK_HALF = SCK_HALF_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             sck,
  output logic             bit_start,
  output logic             frame_start,
  output logic [BIT_W-1:0] bit_idx
);

  localparam int DIV_W = $clog2(2 * SCK_HALF);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * SCK_HALF - 1);

  logic [DIV_W-1:0] div_ctr_reg, div_next;
  logic [BIT_W-1:0] bit_ctr_reg;

  assign bit_start   = run && (div_ctr_reg == DIV_LAST);
  assign frame_start = bit_start && (bit_ctr_reg == BIT_W'(I2S_FRAME_BITS - 1));
  assign div_next    = bit_start ? '0 : div_ctr_reg + DIV_W'(1);
  assign bit_idx     = bit_ctr_reg;

  // Counters idle at zero so the first running cycle is bit 0, low phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_ctr_reg <= '0;
      bit_ctr_reg <= '0;
      sck         <= 1'b0;
    end else if (!run) begin
      div_ctr_reg <= '0;
      bit_ctr_reg <= '0;
      sck         <= 1'b0;
    end else begin
      div_ctr_reg <= div_next;
      sck         <= (div_next >= DIV_W'(SCK_HALF));
      if (bit_start) bit_ctr_reg <= bit_ctr_reg + BIT_W'(1);
    end
  end

endmodule

// File: rtl/i2s_unit.sv
// I2S transmitter: one-pair sample buffer, 64-bit frame shifter and playback FSM.
// Left slot first, MSB first, sample left-justified in a 32-bit slot.
module i2s_unit
  import i2s_unit_pkg::*;
#(
  parameter int SCK_HALF = SCK_HALF_DEFAULT,
  parameter int SAMPLE_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                play_in,
  input  logic                tick_in,
  input  logic [SAMPLE_W-1:0] audio0_in,
  input  logic [SAMPLE_W-1:0] audio1_in,
  output logic                req_out,
  output logic                sck_out,
  output logic                ws_out,
  output logic                sdo_out,
  output logic                underrun_out
);

  localparam int PAD_W = I2S_SLOT_BITS - SAMPLE_W;

  state_t                    state_reg, state_next;
  logic [SAMPLE_W-1:0]       buf_l_reg, buf_r_reg;
  logic                      buf_valid_reg;
  logic [I2S_FRAME_BITS-1:0] shift_reg, load_word;
  logic [I2S_SLOT_BITS-1:0]  slot_l, slot_r;
  logic                      req_reg, req_next, underrun_reg, underrun_next;
  logic                      ws_reg, sdo_reg;
  logic                      load, run, bit_start, frame_start;
  logic [BIT_W-1:0]          bit_idx;

  assign run = (state_reg == PLAY) || (state_reg == STOPPING);

  i2s_clkgen #(.SCK_HALF(SCK_HALF)) u_clkgen (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .sck         (sck_out),
    .bit_start   (bit_start),
    .frame_start (frame_start),
    .bit_idx     (bit_idx)
  );

  for (genvar gi = 0; gi < I2S_SLOT_BITS; gi++) begin : g_slot
    if (gi >= PAD_W) begin : g_data
      assign slot_l[gi] = buf_l_reg[gi-PAD_W];
      assign slot_r[gi] = buf_r_reg[gi-PAD_W];
    end else begin : g_pad
      assign slot_l[gi] = 1'b0;
      assign slot_r[gi] = 1'b0;
    end
  end

  // An empty buffer at a frame boundary transmits silence.
  assign load_word = buf_valid_reg ? {slot_l, slot_r} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (play_in) state_next = FILL;
      FILL: begin
        if (!play_in)          state_next = IDLE;
        else if (buf_valid_reg) state_next = PLAY;
      end
      PLAY:     if (!play_in) state_next = frame_start ? IDLE : STOPPING;
      STOPPING: if (frame_start) state_next = play_in ? PLAY : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    req_next = 1'b0;
    case (state_reg)
      IDLE:           req_next = play_in;
      FILL:           load = play_in && buf_valid_reg;
      PLAY, STOPPING: load = play_in && frame_start;
      default:        load = 1'b0;
    endcase
    if (load) req_next = 1'b1;
    underrun_next = load && !buf_valid_reg;
  end

  // A tick in the load cycle wins the buffer, so valid stays set for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_l_reg     <= '0;
      buf_r_reg     <= '0;
      buf_valid_reg <= 1'b0;
    end else if (state_reg == IDLE) begin
      buf_l_reg     <= '0;
      buf_r_reg     <= '0;
      buf_valid_reg <= 1'b0;
    end else if (tick_in) begin
      buf_l_reg     <= audio0_in;
      buf_r_reg     <= audio1_in;
      buf_valid_reg <= 1'b1;
    end else if (load) begin
      buf_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg    <= '0;
      sdo_reg      <= 1'b0;
      ws_reg       <= 1'b0;
      req_reg      <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      req_reg      <= req_next;
      underrun_reg <= underrun_next;
      if (load) begin
        shift_reg <= load_word;
        sdo_reg   <= load_word[I2S_FRAME_BITS-1];
        ws_reg    <= 1'b0;
      end else if (!run || frame_start) begin
        sdo_reg <= 1'b0;
        ws_reg  <= 1'b0;
      end else if (bit_start) begin
        shift_reg <= {shift_reg[I2S_FRAME_BITS-2:0], 1'b0};
        sdo_reg   <= shift_reg[I2S_FRAME_BITS-2];
        ws_reg    <= ws_for_bit(bit_idx + BIT_W'(1));
      end
    end
  end

  assign req_out      = req_reg;
  assign underrun_out = underrun_reg;
  assign sdo_out      = sdo_reg;
  assign ws_out       = ws_reg;

endmodule

// File: tb/tb_i2s_unit.sv
// Directed bench for i2s_unit: startup vector table, then whole-frame captures
// covering steady state, underrun, overrun, load collision, stop/resume and reset.
module tb_i2s_unit;

  localparam int SCK_HALF   = 2;
  localparam int SAMPLE_W   = 24;
  localparam int FRAME_CLKS = 128 * SCK_HALF;
  localparam logic [63:0] WS_EXP = 64'h0000_0001_FFFF_FFFE;

  logic clk = 1'b0, rst_n = 1'b0, play_in = 1'b0, tick_in = 1'b0;
  logic [SAMPLE_W-1:0] audio0_in = '0, audio1_in = '0;
  logic req_out, sck_out, ws_out, sdo_out, underrun_out;
  int checks = 0, errors = 0;

  typedef struct {
    logic        play;
    logic        tick;
    logic [23:0] l;
    logic [23:0] r;
    logic [4:0]  exp;  // {req, sck, ws, sdo, underrun}
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  i2s_unit #(.SCK_HALF(SCK_HALF), .SAMPLE_W(SAMPLE_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .play_in      (play_in),
    .tick_in      (tick_in),
    .audio0_in    (audio0_in),
    .audio1_in    (audio1_in),
    .req_out      (req_out),
    .sck_out      (sck_out),
    .ws_out       (ws_out),
    .sdo_out      (sdo_out),
    .underrun_out (underrun_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] frame_word(input logic [23:0] l, input logic [23:0] r);
    return {l, 8'h00, r, 8'h00};
  endfunction

  function automatic logic [4:0] outs();
    return {req_out, sck_out, ws_out, sdo_out, underrun_out};
  endfunction

  // Called at the sample point of a frame load; returns at the next frame boundary.
  task automatic run_frame(input string name, input logic [63:0] exp_word,
                           input logic exp_und, input logic exp_req_end,
                           input int t1, input logic [23:0] l1, input logic [23:0] r1,
                           input int t2 = -1, input logic [23:0] l2 = '0,
                           input logic [23:0] r2 = '0,
                           input int stop_at = -1, input int resume_at = -1);
    logic [63:0] sdo_w = '0, ws_w = '0;
    logic und0 = 1'b0;
    int extra_req = 0, extra_und = 0, sck_bad = 0, unstable = 0;
    for (int c = 0; c < FRAME_CLKS; c++) begin
      int b, d;
      b = c / (2 * SCK_HALF);
      d = c % (2 * SCK_HALF);
      if (c == 0) und0 = underrun_out;
      else begin
        if (req_out) extra_req++;
        if (underrun_out) extra_und++;
      end
      if (sck_out !== (d >= SCK_HALF)) sck_bad++;
      if (d == 0) begin
        sdo_w[63-b] = sdo_out;
        ws_w[63-b]  = ws_out;
      end else if (sdo_out !== sdo_w[63-b] || ws_out !== ws_w[63-b]) begin
        unstable++;
      end
      play_in = !(stop_at >= 0 && c >= stop_at && (resume_at < 0 || c < resume_at));
      tick_in = (c == t1) || (c == t2);
      if (c == t2) begin
        audio0_in = l2;
        audio1_in = r2;
      end else if (c == t1) begin
        audio0_in = l1;
        audio1_in = r1;
      end
      step();
    end
    tick_in = 1'b0;
    check({name, "_sdo"}, sdo_w, exp_word);
    check({name, "_ws"}, ws_w, WS_EXP);
    check({name, "_sck"}, 64'(sck_bad), 64'd0);
    check({name, "_stable"}, 64'(unstable), 64'd0);
    check({name, "_und"}, 64'(und0), 64'(exp_und));
    check({name, "_midreq"}, 64'(extra_req), 64'd0);
    check({name, "_midund"}, 64'(extra_und), 64'd0);
    check({name, "_req_next"}, 64'(req_out), 64'(exp_req_end));
    $display("frame %s: sdo=%h ws=%h und=%0b", name, sdo_w, ws_w, und0);
  endtask

  initial begin
    logic [63:0] prev;
    logic [23:0] l, r;
    int n, act;

    // Startup: req on FILL entry, tick, load with req, then bits 0..2 of 0xA5A5A5.
    vecs.push_back('{1'b1, 1'b0, 24'h0,      24'h0,      5'b00000});
    vecs.push_back('{1'b1, 1'b1, 24'hA5A5A5, 24'h5A5A5A, 5'b10000});
    vecs.push_back('{1'b1, 1'b0, 24'h0,      24'h0,      5'b00000});
    vecs.push_back('{1'b1, 1'b0, 24'h0,      24'h0,      5'b10010});
    vecs.push_back('{1'b1, 1'b0, 24'h0,      24'h0,      5'b00010});
    vecs.push_back('{1'b1, 1'b1, 24'hA5A5A5, 24'h5A5A5A, 5'b01010});
    vecs.push_back('{1'b1, 1'b0, 24'h0,      24'h0,      5'b01010});
    vecs.push_back('{1'b1, 1'b0, 24'h0,      24'h0,      5'b00000});
    vecs.push_back('{1'b1, 1'b0, 24'h0,      24'h0,      5'b00000});
    vecs.push_back('{1'b1, 1'b0, 24'h0,      24'h0,      5'b01000});
    vecs.push_back('{1'b1, 1'b0, 24'h0,      24'h0,      5'b01000});
    vecs.push_back('{1'b1, 1'b0, 24'h0,      24'h0,      5'b00010});

    step();
    step();
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      check($sformatf("vec%0d", i), 64'(outs()), 64'(vecs[i].exp));
      $display("vec %0d: outs=%b exp=%b", i, outs(), vecs[i].exp);
      play_in   = vecs[i].play;
      tick_in   = vecs[i].tick;
      audio0_in = vecs[i].l;
      audio1_in = vecs[i].r;
      step();
    end
    tick_in = 1'b0;

    n = 0;
    while (req_out !== 1'b1 && n < 2 * FRAME_CLKS) begin
      step();
      n++;
    end
    check("first_period", 64'(n), 64'(FRAME_CLKS - 9));

    run_frame("start", 64'hA5A5A5005A5A5A00, 1'b0, 1'b1, 7, 24'h13579B, 24'hECA864);
    prev = frame_word(24'h13579B, 24'hECA864);
    for (int i = 1; i < 10; i++) begin
      l = 24'(32'h13579B * (i + 1));
      r = ~l;
      run_frame($sformatf("steady%0d", i), prev, 1'b0, 1'b1, 3 + 2 * i, l, r);
      prev = frame_word(l, r);
    end

    run_frame("pre_under", prev, 1'b0, 1'b1, -1, '0, '0);
    run_frame("underrun", 64'h0, 1'b1, 1'b1, 4, 24'h123456, 24'hFEDCBA);
    run_frame("resume", 64'h12345600FEDCBA00, 1'b0, 1'b1,
              5, 24'h111111, 24'h222222, 60, 24'h333333, 24'h444444);
    run_frame("overrun", 64'h3333330044444400, 1'b0, 1'b1,
              10, 24'hABCDEF, 24'h13579B, 255, 24'h0F0F0F, 24'hF0F0F0);
    run_frame("collide_old", 64'hABCDEF0013579B00, 1'b0, 1'b1, -1, '0, '0);
    run_frame("collide_new", 64'h0F0F0F00F0F0F000, 1'b0, 1'b1, 6, 24'h800001, 24'h7FFFFE);
    run_frame("stop", 64'h800001007FFFFE00, 1'b0, 1'b0, -1, '0, '0, -1, '0, '0, 160, -1);

    check("idle_outputs", 64'(outs()), 64'd0);
    act = 0;
    for (int i = 0; i < 300; i++) begin
      if (outs() != 5'b0) act++;
      step();
    end
    check("idle_quiet", 64'(act), 64'd0);

    play_in = 1'b1;
    step();
    check("restart_req", 64'(req_out), 64'd1);
    tick_in   = 1'b1;
    audio0_in = 24'h0AB0CD;
    audio1_in = 24'hF00F00;
    step();
    tick_in = 1'b0;
    check("restart_fill", 64'(req_out), 64'd0);
    step();
    check("restart_load", 64'(req_out), 64'd1);
    run_frame("stop_resume", 64'h0AB0CD00F00F0000, 1'b0, 1'b1,
              5, 24'h246802, 24'h13579A, -1, '0, '0, 160, 200);
    run_frame("after_resume", 64'h2468020013579A00, 1'b0, 1'b1, -1, '0, '0);

    repeat (40) step();
    rst_n = 1'b0;
    #2;
    check("reset_async", 64'(outs()), 64'd0);
    play_in = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      if (outs() != 5'b0) act++;
      step();
    end
    check("reset_quiet", 64'(act), 64'd0);
    play_in = 1'b1;
    step();
    check("reset_play_req", 64'(req_out), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
